// File: rtl/registro_pkg.sv
// rtl/registro_pkg.sv - operation encodings for the universal register
package registro_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd2;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd3;
    localparam logic [OP_W-1:0] OP_ROL  = 3'd4;
    localparam logic [OP_W-1:0] OP_ROR  = 3'd5;
    localparam logic [OP_W-1:0] OP_INC  = 3'd6;
    localparam logic [OP_W-1:0] OP_DEC  = 3'd7;

endpackage

// File: rtl/registro_next.sv
// rtl/registro_next.sv - next-state datapath: value, serial out and carry per op
module registro_next
    import registro_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] cur,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_cur,
    input  logic             carry_cur,
    output logic [WIDTH-1:0] nxt,
    output logic             ser_nxt,
    output logic             carry_nxt
);

    logic [WIDTH:0] inc_sum;

    assign inc_sum = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        nxt       = cur;
        ser_nxt   = ser_cur;
        carry_nxt = carry_cur;
        case (op)
            OP_HOLD: ;
            OP_LOAD: begin
                nxt       = data_in;
                carry_nxt = 1'b0;
            end
            OP_SHL: begin
                nxt     = {cur[WIDTH-2:0], ser_in};
                ser_nxt = cur[WIDTH-1];
            end
            OP_SHR: begin
                nxt     = {ser_in, cur[WIDTH-1:1]};
                ser_nxt = cur[0];
            end
            OP_ROL: begin
                nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
                ser_nxt = cur[WIDTH-1];
            end
            OP_ROR: begin
                nxt     = {cur[0], cur[WIDTH-1:1]};
                ser_nxt = cur[0];
            end
            OP_INC: begin
                nxt       = inc_sum[WIDTH-1:0];
                carry_nxt = inc_sum[WIDTH];
            end
            OP_DEC: begin
                // Borrow only when wrapping from zero to all-ones
                nxt       = cur - {{(WIDTH-1){1'b0}}, 1'b1};
                carry_nxt = (cur == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/registro_universal.sv
// rtl/registro_universal.sv - WIDTH-bit universal register; REGISTRO_PARITY_EN adds parity output
module registro_universal
    import registro_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [OP_W-1:0]  op,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Data_out,
    output logic             ser_out,
    output logic             carry,
`ifdef REGISTRO_PARITY_EN
    output logic             parity,
`endif
    output logic             zero
);

    logic [WIDTH-1:0] nxt;
    logic             ser_nxt;
    logic             carry_nxt;

    registro_next #(.WIDTH(WIDTH)) u_next (
        .op        (op),
        .cur       (Data_out),
        .ser_in    (ser_in),
        .data_in   (Data_in),
        .ser_cur   (ser_out),
        .carry_cur (carry),
        .nxt       (nxt),
        .ser_nxt   (ser_nxt),
        .carry_nxt (carry_nxt)
    );

    // HOLD yields nxt == Data_out, so flags stay consistent without a separate enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_out <= RESET_VAL;
            ser_out  <= 1'b0;
            carry    <= 1'b0;
            zero     <= (RESET_VAL == '0);
        end else if (clr) begin
            Data_out <= '0;
            ser_out  <= 1'b0;
            carry    <= 1'b0;
            zero     <= 1'b1;
        end else begin
            Data_out <= nxt;
            ser_out  <= ser_nxt;
            carry    <= carry_nxt;
            zero     <= (nxt == '0);
        end
    end

`ifdef REGISTRO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity <= ^RESET_VAL;
        end else if (clr) begin
            parity <= 1'b0;
        end else begin
            parity <= ^nxt;
        end
    end
`endif

endmodule
